rx_fifo_ch: RTL and testbench

//   Parametrised receive buffer: accepts words on a valid/ready handshake gated by an upstream busy flag.

---
 rtl/rx_fifo_ch.sv | 75 +++++++
 tb/tb_rx_fifo_ch.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rx_fifo_ch.sv
// rx_fifo_ch: DEPTH-entry first-word-fall-through receive FIFO with a busy-gated, registered ready.
// Define RX_STATS_EN to build saturating accept/pop counters (accept_cnt_o, pop_cnt_o).
module rx_fifo_ch #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       busy,
   input  logic                       valid_i,
   input  logic [DATA_W-1:0]          data_i,
   output logic                       ready_o,
   output logic                       valid_o,
   output logic [DATA_W-1:0]          data_o,
   input  logic                       ready_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
`ifdef RX_STATS_EN
   output logic [CNT_W-1:0]           accept_cnt_o,
   output logic [CNT_W-1:0]           pop_cnt_o,
`endif
   output logic                       stall_o
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count, count_next;
   logic              push, pop;

   assign push       = valid_i && ready_o;
   assign pop        = valid_o && ready_i;
   assign count_next = count + CW'(push) - CW'(pop);

   assign count_o = count;
   assign valid_o = (count != '0);
   assign data_o  = valid_o ? mem[rd_ptr] : '0;

   // Storage has no reset; stale entries are masked by valid_o.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ready_o <= 1'b0;
         stall_o <= 1'b0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         count   <= count_next;
         // Looking at count_next keeps a push from ever landing on a full FIFO.
         ready_o <= !busy && (count_next < CW'(DEPTH));
         if (valid_i && !ready_o) stall_o <= 1'b1;
      end
   end

`ifdef RX_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         accept_cnt_o <= '0;
         pop_cnt_o    <= '0;
      end else begin
         if (push && (accept_cnt_o != '1)) accept_cnt_o <= accept_cnt_o + 1'b1;
         if (pop  && (pop_cnt_o    != '1)) pop_cnt_o    <= pop_cnt_o + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_rx_fifo_ch.sv
// Directed bench for rx_fifo_ch: a DEPTH=4 instance (fill/drain/busy/reset/stats)
// and a DEPTH=3 instance (pointer wrap with continuous push+pop).
module tb_rx_fifo_ch;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // DEPTH=4 instance
   logic       busy = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
   logic [3:0] data_i = '0;
   logic       ready_o, valid_o, stall_o;
   logic [3:0] data_o;
   logic [2:0] count_o;
   // DEPTH=3 instance
   logic       busy3 = 1'b0, valid3_i = 1'b0, ready3_i = 1'b0;
   logic [3:0] data3_i = '0;
   logic       ready3_o, valid3_o, stall3_o;
   logic [3:0] data3_o;
   logic [1:0] count3_o;
`ifdef RX_STATS_EN
   logic [1:0] acc_cnt, pop_cnt, acc3_cnt, pop3_cnt;
`endif

   rx_fifo_ch #(.DATA_W(4), .DEPTH(4), .CNT_W(2)) u_dut (
      .clk(clk), .rst(rst), .busy(busy), .valid_i(valid_i), .data_i(data_i),
      .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
      .count_o(count_o),
`ifdef RX_STATS_EN
      .accept_cnt_o(acc_cnt), .pop_cnt_o(pop_cnt),
`endif
      .stall_o(stall_o));

   rx_fifo_ch #(.DATA_W(4), .DEPTH(3), .CNT_W(2)) u_dut3 (
      .clk(clk), .rst(rst), .busy(busy3), .valid_i(valid3_i), .data_i(data3_i),
      .ready_o(ready3_o), .valid_o(valid3_o), .data_o(data3_o), .ready_i(ready3_i),
      .count_o(count3_o),
`ifdef RX_STATS_EN
      .accept_cnt_o(acc3_cnt), .pop_cnt_o(pop3_cnt),
`endif
      .stall_o(stall3_o));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      tick; tick;
      chk("rst_ready", 32'(ready_o), 0);
      chk("rst_count", 32'(count_o), 0);
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_data",  32'(data_o),  0);
      chk("rst_stall", 32'(stall_o), 0);
      rst = 1'b0;
      chk("rel_ready_lo", 32'(ready_o), 0);
      tick;
      chk("rel_ready_hi",  32'(ready_o),  1);
      chk("rel_ready3_hi", 32'(ready3_o), 1);

      // fill 1..4 with no consumer
      for (int i = 1; i <= 4; i++) begin
         valid_i = 1'b1; data_i = 4'(i);
         tick;
         chk("fill_count", 32'(count_o), 32'(i));
      end
      chk("full_ready", 32'(ready_o), 0);
      chk("full_head",  32'(data_o),  1);
      chk("full_stall_clr", 32'(stall_o), 0);
      data_i = 4'h5;
      tick;
      chk("ovf_count", 32'(count_o), 4);
      chk("ovf_stall", 32'(stall_o), 1);
      chk("ovf_head",  32'(data_o),  1);
`ifdef RX_STATS_EN
      chk("stat_acc_sat", 32'(acc_cnt), 3);
      chk("stat_pop0",    32'(pop_cnt), 0);
`endif

      // drain in order
      valid_i = 1'b0; ready_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_valid", 32'(valid_o), 1);
         chk("drain_data",  32'(data_o),  32'(i));
         tick;
      end
      chk("empty_valid", 32'(valid_o), 0);
      chk("empty_count", 32'(count_o), 0);
      chk("empty_data",  32'(data_o),  0);
      chk("empty_ready", 32'(ready_o), 1);

      // one-cycle busy while streaming; C is held through the stall
      valid_i = 1'b1; data_i = 4'hA;
      tick;
      chk("busy_a", 32'(data_o), 32'hA);
      busy = 1'b1; data_i = 4'hB;
      tick;
      chk("busy_ready_lo", 32'(ready_o), 0);
      chk("busy_b",        32'(data_o),  32'hB);
      busy = 1'b0; data_i = 4'hC;
      tick;
      chk("busy_ready_hi", 32'(ready_o), 1);
      chk("busy_gap",      32'(valid_o), 0);
      tick;
      chk("busy_c",        32'(data_o),  32'hC);
      chk("busy_c_count",  32'(count_o), 1);
      valid_i = 1'b0;
      tick;
      chk("busy_end_count", 32'(count_o), 0);
`ifdef RX_STATS_EN
      chk("stat_acc_end", 32'(acc_cnt), 3);
      chk("stat_pop_end", 32'(pop_cnt), 3);
`endif

      // DEPTH=3: continuous push+pop, pointers wrap several times
      ready3_i = 1'b1;
      for (int i = 0; i <= 9; i++) begin
         valid3_i = 1'b1; data3_i = 4'(i);
         tick;
         chk("wrap_data",  32'(data3_o),  32'(i));
         chk("wrap_count", 32'(count3_o), 1);
      end
      valid3_i = 1'b0;
      tick;
      chk("wrap_empty", 32'(valid3_o), 0);

      // reset mid-stream
      ready_i = 1'b0; valid_i = 1'b1; data_i = 4'h7;
      tick;
      data_i = 4'h8;
      tick;
      valid_i = 1'b0;
      chk("mid_count", 32'(count_o), 2);
      rst = 1'b1;
      #1;
      chk("mid_rst_count", 32'(count_o), 0);
      chk("mid_rst_valid", 32'(valid_o), 0);
      chk("mid_rst_data",  32'(data_o),  0);
      chk("mid_rst_ready", 32'(ready_o), 0);
      chk("mid_rst_stall", 32'(stall_o), 0);
`ifdef RX_STATS_EN
      chk("mid_rst_acc", 32'(acc_cnt), 0);
      chk("mid_rst_pop", 32'(pop_cnt), 0);
`endif
      tick;
      rst = 1'b0;
      chk("mid_rel_ready_lo", 32'(ready_o), 0);
      tick;
      chk("mid_rel_ready_hi", 32'(ready_o), 1);
      chk("mid_rel_empty",    32'(valid_o), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
